apu_frame_sequencer: RTL



---
 rtl/apu_frame_sequencer_if.sv | 21 ++
 rtl/apu_frame_sequencer.sv | 134 +++++++++++++
 2 files changed

// File: rtl/apu_frame_sequencer_if.sv
// Bundles the CPU-side frame counter controls and the channel clock-enable outputs.
interface apu_frame_sequencer_if;
    logic       cpu_clk_en;
    logic       reg_write;
    logic [1:0] reg_data;
    logic       irq_ack;
    logic       quarter_clk_en;
    logic       half_clk_en;
    logic       frame_irq;
    logic       mode;

    modport master (
        output cpu_clk_en, reg_write, reg_data, irq_ack,
        input  quarter_clk_en, half_clk_en, frame_irq, mode
    );

    modport slave (
        input  cpu_clk_en, reg_write, reg_data, irq_ack,
        output quarter_clk_en, half_clk_en, frame_irq, mode
    );
endinterface

// File: rtl/apu_frame_sequencer.sv
// APU $4017 frame counter: quarter/half-frame clock enables in 4- or 5-step mode.
// Frame IRQ logic is built only when APU_FRAME_IRQ_EN is defined.
module apu_frame_sequencer #(
    parameter int unsigned Q1_CYC = 7457,
    parameter int unsigned H1_CYC = 14913,
    parameter int unsigned Q3_CYC = 22371,
    parameter int unsigned S4_CYC = 29829,
    parameter int unsigned S5_CYC = 37281
) (
    input  logic                  clk,
    input  logic                  rst,
    apu_frame_sequencer_if.slave  bus
);
    logic        tick;
    logic [15:0] cyc_q, cyc_d;
    logic        parity_q, parity_d;
    logic        mode_q, mode_d;
    logic        rst_pend_q, rst_pend_d;
    logic [2:0]  rst_dly_q, rst_dly_d;
    logic        quarter_q, quarter_d;
    logic        half_q, half_d;
    logic        at_q1, at_h1, at_q3, at_s4, at_s5, at_end, force_rst;

    assign tick   = bus.cpu_clk_en;
    assign at_q1  = (cyc_q == 16'(Q1_CYC));
    assign at_h1  = (cyc_q == 16'(H1_CYC));
    assign at_q3  = (cyc_q == 16'(Q3_CYC));
    assign at_s4  = (cyc_q == 16'(S4_CYC));
    assign at_s5  = (cyc_q == 16'(S5_CYC));
    assign at_end = mode_q ? at_s5 : at_s4;
    // A new write restarts the delay, so it suppresses a countdown landing on the same tick.
    assign force_rst = tick && rst_pend_q && !bus.reg_write && (rst_dly_q == 3'd1);

    always_comb begin
        cyc_d      = cyc_q;
        parity_d   = parity_q;
        mode_d     = mode_q;
        rst_pend_d = rst_pend_q;
        rst_dly_d  = rst_dly_q;
        quarter_d  = 1'b0;
        half_d     = 1'b0;
        if (tick) begin
            parity_d  = ~parity_q;
            cyc_d     = at_end ? 16'd0 : cyc_q + 16'd1;
            quarter_d = at_q1 | at_h1 | at_q3 | at_end;
            half_d    = at_h1 | at_end;
            if (bus.reg_write) begin
                mode_d     = bus.reg_data[1];
                rst_pend_d = 1'b1;
                rst_dly_d  = parity_q ? 3'd4 : 3'd3;
            end else if (rst_pend_q) begin
                rst_dly_d = rst_dly_q - 3'd1;
                if (force_rst) begin
                    cyc_d      = 16'd0;
                    rst_pend_d = 1'b0;
                    quarter_d  = mode_q;
                    half_d     = mode_q;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_q      <= 16'd0;
            parity_q   <= 1'b0;
            mode_q     <= 1'b0;
            rst_pend_q <= 1'b0;
            rst_dly_q  <= 3'd0;
            quarter_q  <= 1'b0;
            half_q     <= 1'b0;
        end else begin
            cyc_q      <= cyc_d;
            parity_q   <= parity_d;
            mode_q     <= mode_d;
            rst_pend_q <= rst_pend_d;
            rst_dly_q  <= rst_dly_d;
            quarter_q  <= quarter_d;
            half_q     <= half_d;
        end
    end

    assign bus.quarter_clk_en = quarter_q;
    assign bus.half_clk_en    = half_q;
    assign bus.mode           = mode_q;

`ifdef APU_FRAME_IRQ_EN
    logic inhibit_q, inhibit_d;
    logic irq_q, irq_d;
    logic irq_tail_q, irq_tail_d;
    logic irq_set;

    // irq_tail carries the third set into the first tick after the 4-step wrap.
    assign irq_set = !mode_q && !inhibit_q &&
                     ((cyc_q == 16'(S4_CYC - 1)) || at_s4 || irq_tail_q);

    always_comb begin
        inhibit_d  = inhibit_q;
        irq_d      = irq_q;
        irq_tail_d = irq_tail_q;
        if (tick) begin
            irq_tail_d = !mode_q && at_s4;
            if (bus.reg_write) begin
                inhibit_d = bus.reg_data[0];
            end
            if (bus.reg_write && bus.reg_data[0]) begin
                irq_d = 1'b0;
            end else if (irq_set) begin
                irq_d = 1'b1;
            end else if (bus.irq_ack) begin
                irq_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            inhibit_q  <= 1'b0;
            irq_q      <= 1'b0;
            irq_tail_q <= 1'b0;
        end else begin
            inhibit_q  <= inhibit_d;
            irq_q      <= irq_d;
            irq_tail_q <= irq_tail_d;
        end
    end

    assign bus.frame_irq = irq_q;
`else
    logic unused_irq_inputs;
    assign unused_irq_inputs = ^{bus.reg_data[0], bus.irq_ack};
    assign bus.frame_irq     = 1'b0;
`endif
endmodule
